// File: rtl/sd_host_pkg.sv
// Shared constants and types for the SD host register bank: address map,
// STATUS bit layout and the execute sequencer state encoding.
package sd_host_pkg;

  localparam int unsigned NUM_RW_REGS = 13;

  localparam logic [4:0] REG_STATUS    = 5'd13;
  localparam logic [4:0] REG_RESP      = 5'd14;
  localparam logic [4:0] REG_LAST      = 5'd15;
  localparam logic [4:0] ADR_CMD_EXEC  = 5'd16;
  localparam logic [4:0] ADR_FIFO_WR   = 5'd17;
  localparam logic [4:0] ADR_FIFO_RD   = 5'd18;
  localparam logic [4:0] ADR_DATA_EXEC = 5'd19;

  localparam int unsigned ST_CMD_BUSY  = 0;
  localparam int unsigned ST_DATA_BUSY = 1;
  localparam int unsigned ST_TX_FULL   = 2;
  localparam int unsigned ST_TX_EMPTY  = 3;
  localparam int unsigned ST_RX_FULL   = 4;
  localparam int unsigned ST_RX_EMPTY  = 5;
  localparam int unsigned ST_OVERRUN   = 6;

  typedef enum logic [1:0] {
    SEQ_IDLE      = 2'd0,
    SEQ_CMD_BUSY  = 2'd1,
    SEQ_DATA_BUSY = 2'd2
  } seq_state_e;

endpackage

// File: rtl/sd_sync_fifo.sv
// Single-clock show-ahead FIFO; flags come from the registered occupancy count,
// so they change the cycle after the push or pop that moves them.
module sd_sync_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/sd_host_regbank.sv
// Host register bank, TX/RX data FIFOs and command/data execute sequencer
// sitting between the Wishbone slave and the SD command/data cores.
module sd_host_regbank
  import sd_host_pkg::*;
#(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reg_read_en,
  input  logic              reg_write_en,
  input  logic              fifo_read_en,
  input  logic              fifo_write_en,
  input  logic [4:0]        adr_i,
  input  logic [DATA_W-1:0] host_data_i,
  input  logic              new_command,
  input  logic              new_data,
  output logic [DATA_W-1:0] host_data_o,
  output logic              fifo_write_wait,
  output logic              fifo_read_wait,
  output logic              cmd_done_o,
  output logic              data_done_o,
  output logic              cmd_start_o,
  output logic              data_start_o,
  output logic [DATA_W-1:0] cmd_cfg_o,
  output logic [DATA_W-1:0] data_cfg_o,
  input  logic              cmd_complete_i,
  input  logic [DATA_W-1:0] cmd_response_i,
  input  logic              data_complete_i,
  input  logic              tx_rd_en_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_empty_o,
  input  logic              rx_wr_en_i,
  input  logic [DATA_W-1:0] rx_data_i,
  output logic              rx_full_o
);

  logic [DATA_W-1:0] regs_q [NUM_RW_REGS];
  logic [DATA_W-1:0] resp_q, status, rx_head;
  logic              tx_full, rx_empty, resp_load;
  logic              cmd_start_q, cmd_start_d, data_start_q, data_start_d;
  logic              cmd_done_q, cmd_done_d, data_done_q, data_done_d;
  logic              overrun_q, overrun_d;
  seq_state_e        state_q, state_d;

  sd_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock(clock), .reset(reset), .push_i(fifo_write_en), .pop_i(tx_rd_en_i),
    .data_i(host_data_i), .data_o(tx_data_o), .full_o(tx_full), .empty_o(tx_empty_o)
  );

  sd_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock(clock), .reset(reset), .push_i(rx_wr_en_i), .pop_i(fifo_read_en),
    .data_i(rx_data_i), .data_o(rx_head), .full_o(rx_full_o), .empty_o(rx_empty)
  );

  assign fifo_write_wait = tx_full;
  assign fifo_read_wait  = rx_empty;
  assign cmd_cfg_o       = regs_q[0];
  assign data_cfg_o      = regs_q[1];
  assign cmd_start_o     = cmd_start_q;
  assign data_start_o    = data_start_q;
  assign cmd_done_o      = cmd_done_q;
  assign data_done_o     = data_done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_RW_REGS; i++) regs_q[i] <= '0;
    end else if (reg_write_en && (adr_i < REG_STATUS)) begin
      regs_q[adr_i[3:0]] <= host_data_i;
    end
  end

  always_comb begin
    status               = '0;
    status[ST_CMD_BUSY]  = (state_q == SEQ_CMD_BUSY);
    status[ST_DATA_BUSY] = (state_q == SEQ_DATA_BUSY);
    status[ST_TX_FULL]   = tx_full;
    status[ST_TX_EMPTY]  = tx_empty_o;
    status[ST_RX_FULL]   = rx_full_o;
    status[ST_RX_EMPTY]  = rx_empty;
    status[ST_OVERRUN]   = overrun_q;
  end

  // Register reads take priority over RX pops; an empty RX FIFO reads as 0.
  always_comb begin
    host_data_o = '0;
    if (reg_read_en) begin
      if (adr_i < REG_STATUS)       host_data_o = regs_q[adr_i[3:0]];
      else if (adr_i == REG_STATUS) host_data_o = status;
      else if (adr_i == REG_RESP)   host_data_o = resp_q;
    end else if (fifo_read_en && !rx_empty) begin
      host_data_o = rx_head;
    end
  end

  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cmd_start_d  = 1'b0;
    data_start_d = 1'b0;
    cmd_done_d   = 1'b0;
    data_done_d  = 1'b0;
    resp_load    = 1'b0;
    overrun_d    = overrun_q;
    if (reg_write_en && (adr_i == REG_STATUS) && host_data_i[ST_OVERRUN]) overrun_d = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (new_command) begin
          state_d     = SEQ_CMD_BUSY;
          cmd_start_d = 1'b1;
          if (new_data) overrun_d = 1'b1;
        end else if (new_data) begin
          state_d      = SEQ_DATA_BUSY;
          data_start_d = 1'b1;
        end
      end
      SEQ_CMD_BUSY: begin
        if (new_command || new_data) overrun_d = 1'b1;
        if (cmd_complete_i) begin
          state_d    = SEQ_IDLE;
          cmd_done_d = 1'b1;
          resp_load  = 1'b1;
        end
      end
      SEQ_DATA_BUSY: begin
        if (new_command || new_data) overrun_d = 1'b1;
        if (data_complete_i) begin
          state_d     = SEQ_IDLE;
          data_done_d = 1'b1;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= SEQ_IDLE;
      cmd_start_q  <= 1'b0;
      data_start_q <= 1'b0;
      cmd_done_q   <= 1'b0;
      data_done_q  <= 1'b0;
      overrun_q    <= 1'b0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      cmd_start_q  <= cmd_start_d;
      data_start_q <= data_start_d;
      cmd_done_q   <= cmd_done_d;
      data_done_q  <= data_done_d;
      overrun_q    <= overrun_d;
      if (resp_load) resp_q <= cmd_response_i;
    end
  end

endmodule

// File: tb/tb_sd_host_regbank.sv
// Self-checking bench for sd_host_regbank: directed steps plus randomized
// traffic compared against a queue/array reference model of the register bank.
module tb_sd_host_regbank;
  import sd_host_pkg::*;

  localparam int DW    = 128;
  localparam int DEPTH = 8;
  typedef logic [DW-1:0] word_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       reg_read_en = 1'b0, reg_write_en = 1'b0;
  logic       fifo_read_en = 1'b0, fifo_write_en = 1'b0;
  logic [4:0] adr_i = '0;
  word_t      host_data_i = '0;
  logic       new_command = 1'b0, new_data = 1'b0;
  word_t      host_data_o;
  logic       fifo_write_wait, fifo_read_wait;
  logic       cmd_done_o, data_done_o, cmd_start_o, data_start_o;
  word_t      cmd_cfg_o, data_cfg_o;
  logic       cmd_complete_i = 1'b0;
  word_t      cmd_response_i = '0;
  logic       data_complete_i = 1'b0;
  logic       tx_rd_en_i = 1'b0;
  word_t      tx_data_o;
  logic       tx_empty_o;
  logic       rx_wr_en_i = 1'b0;
  word_t      rx_data_i = '0;
  logic       rx_full_o;

  sd_host_regbank #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .reg_read_en(reg_read_en), .reg_write_en(reg_write_en),
    .fifo_read_en(fifo_read_en), .fifo_write_en(fifo_write_en),
    .adr_i(adr_i), .host_data_i(host_data_i),
    .new_command(new_command), .new_data(new_data),
    .host_data_o(host_data_o),
    .fifo_write_wait(fifo_write_wait), .fifo_read_wait(fifo_read_wait),
    .cmd_done_o(cmd_done_o), .data_done_o(data_done_o),
    .cmd_start_o(cmd_start_o), .data_start_o(data_start_o),
    .cmd_cfg_o(cmd_cfg_o), .data_cfg_o(data_cfg_o),
    .cmd_complete_i(cmd_complete_i), .cmd_response_i(cmd_response_i),
    .data_complete_i(data_complete_i),
    .tx_rd_en_i(tx_rd_en_i), .tx_data_o(tx_data_o), .tx_empty_o(tx_empty_o),
    .rx_wr_en_i(rx_wr_en_i), .rx_data_i(rx_data_i), .rx_full_o(rx_full_o)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays, queues and busy flags.
  word_t ref_regs [13];
  word_t ref_resp;
  word_t tx_q [$];
  word_t rx_q [$];
  bit    ref_cmd_busy, ref_data_busy, ref_overrun;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic word_t rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic word_t ref_status();
    word_t s = '0;
    s[0] = ref_cmd_busy;
    s[1] = ref_data_busy;
    s[2] = (tx_q.size() == DEPTH);
    s[3] = (tx_q.size() == 0);
    s[4] = (rx_q.size() == DEPTH);
    s[5] = (rx_q.size() == 0);
    s[6] = ref_overrun;
    return s;
  endfunction

  function automatic word_t ref_read(input logic [4:0] a);
    if (a < 13)  return ref_regs[a];
    if (a == 13) return ref_status();
    if (a == 14) return ref_resp;
    return '0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    foreach (ref_regs[i]) ref_regs[i] = '0;
    ref_resp = '0;
    tx_q.delete();
    rx_q.delete();
    ref_cmd_busy  = 1'b0;
    ref_data_busy = 1'b0;
    ref_overrun   = 1'b0;
  endtask

  task automatic wr_reg(input logic [4:0] a, input word_t d);
    reg_write_en = 1'b1;
    adr_i        = a;
    host_data_i  = d;
    tick();
    reg_write_en = 1'b0;
    if (a < 13) ref_regs[a] = d;
    else if (a == 13 && d[6]) ref_overrun = 1'b0;
  endtask

  task automatic rd_reg(input logic [4:0] a, input string tag);
    reg_read_en = 1'b1;
    adr_i       = a;
    #1;
    check($sformatf("%s_adr%0d", tag, a), host_data_o, ref_read(a));
    tick();
    reg_read_en = 1'b0;
  endtask

  // One cycle of FIFO traffic on both sides; checks same-cycle read data and flags.
  task automatic fifo_cycle(input bit tx_push, input word_t tx_d, input bit tx_pop,
                            input bit rx_push, input word_t rx_d, input bit rx_pop,
                            input string tag);
    bit tx_pop_ok, tx_push_ok, rx_pop_ok, rx_push_ok;
    fifo_write_en = tx_push;
    host_data_i   = tx_d;
    tx_rd_en_i    = tx_pop;
    rx_wr_en_i    = rx_push;
    rx_data_i     = rx_d;
    fifo_read_en  = rx_pop;
    #1;
    check({tag, "_flags"}, word_t'({fifo_write_wait, tx_empty_o, fifo_read_wait, rx_full_o}),
          word_t'({tx_q.size() == DEPTH, tx_q.size() == 0, rx_q.size() == 0, rx_q.size() == DEPTH}));
    if (tx_q.size() > 0) check({tag, "_tx_head"}, tx_data_o, tx_q[0]);
    if (rx_pop) check({tag, "_rx_read"}, host_data_o, (rx_q.size() > 0) ? rx_q[0] : '0);
    tick();
    tx_pop_ok  = tx_pop && tx_q.size() > 0;
    tx_push_ok = tx_push && tx_q.size() < DEPTH;
    rx_pop_ok  = rx_pop && rx_q.size() > 0;
    rx_push_ok = rx_push && rx_q.size() < DEPTH;
    if (tx_pop_ok)  void'(tx_q.pop_front());
    if (tx_push_ok) tx_q.push_back(tx_d);
    if (rx_pop_ok)  void'(rx_q.pop_front());
    if (rx_push_ok) rx_q.push_back(rx_d);
    fifo_write_en = 1'b0;
    tx_rd_en_i    = 1'b0;
    rx_wr_en_i    = 1'b0;
    fifo_read_en  = 1'b0;
  endtask

  // One cycle of sequencer inputs; checks the pulses that appear the next cycle.
  task automatic seq_cycle(input bit nc, input bit nd, input bit cc, input bit dc,
                           input word_t r, input string tag);
    bit ecs = 0, eds = 0, ecd = 0, edd = 0;
    new_command     = nc;
    new_data        = nd;
    cmd_complete_i  = cc;
    data_complete_i = dc;
    cmd_response_i  = r;
    tick();
    if (!ref_cmd_busy && !ref_data_busy) begin
      if (nc) begin
        ref_cmd_busy = 1'b1;
        ecs = 1'b1;
        if (nd) ref_overrun = 1'b1;
      end else if (nd) begin
        ref_data_busy = 1'b1;
        eds = 1'b1;
      end
    end else begin
      if (nc || nd) ref_overrun = 1'b1;
      if (ref_cmd_busy && cc) begin
        ref_cmd_busy = 1'b0;
        ecd = 1'b1;
        ref_resp = r;
      end
      if (ref_data_busy && dc) begin
        ref_data_busy = 1'b0;
        edd = 1'b1;
      end
    end
    check({tag, "_pulses"}, word_t'({cmd_start_o, data_start_o, cmd_done_o, data_done_o}),
          word_t'({ecs, eds, ecd, edd}));
    new_command     = 1'b0;
    new_data        = 1'b0;
    cmd_complete_i  = 1'b0;
    data_complete_i = 1'b0;
  endtask

  initial begin
    logic [4:0] exec_adrs [4];
    exec_adrs[0] = ADR_CMD_EXEC;
    exec_adrs[1] = ADR_FIFO_WR;
    exec_adrs[2] = ADR_FIFO_RD;
    exec_adrs[3] = ADR_DATA_EXEC;

    // Reset state
    do_reset();
    check("rst_host_data", host_data_o, '0);
    check("rst_flags", word_t'({fifo_write_wait, fifo_read_wait, tx_empty_o, rx_full_o}), word_t'(4'b0110));
    check("rst_pulses", word_t'({cmd_start_o, data_start_o, cmd_done_o, data_done_o}), '0);
    check("rst_cmd_cfg", cmd_cfg_o, '0);
    check("rst_data_cfg", data_cfg_o, '0);
    rd_reg(13, "rst_status");
    check("rst_status_const", ref_status(), word_t'(7'h28));

    // Register round-trip and read-only registers
    wr_reg(3, {16{8'hA5}});
    rd_reg(3, "roundtrip");
    wr_reg(13, '1);
    rd_reg(13, "status_after_write");
    wr_reg(14, rand_word());
    wr_reg(15, rand_word());
    rd_reg(14, "resp_ro");
    rd_reg(15, "reserved");
    foreach (exec_adrs[i]) begin
      wr_reg(exec_adrs[i], rand_word());
      rd_reg(exec_adrs[i], "high_adr");
    end

    // Random register traffic
    repeat (40) begin
      wr_reg(5'($urandom_range(0, 31)), rand_word());
      if ($urandom_range(0, 1) == 1) rd_reg(5'($urandom_range(0, 31)), "rand_rd");
    end
    for (int a = 0; a <= int'(REG_LAST); a++) rd_reg(5'(a), "sweep");
    check("cmd_cfg", cmd_cfg_o, ref_regs[0]);
    check("data_cfg", data_cfg_o, ref_regs[1]);

    // TX fill, overflow drop, ordered drain
    for (int i = 1; i <= 8; i++) fifo_cycle(1, word_t'(i), 0, 0, '0, 0, "tx_fill");
    check("tx_full_after_8", word_t'(fifo_write_wait), word_t'(1));
    fifo_cycle(1, word_t'(9), 0, 0, '0, 0, "tx_overflow");
    rd_reg(13, "status_tx_full");
    for (int i = 1; i <= 8; i++) fifo_cycle(0, '0, 1, 0, '0, 0, "tx_drain");
    check("tx_empty_after_drain", word_t'(tx_empty_o), word_t'(1));
    fifo_cycle(0, '0, 1, 0, '0, 0, "tx_pop_empty");

    // Random traffic on both FIFOs: fill-biased then drain-biased
    for (int i = 0; i < 80; i++) begin
      int p_push = (i < 40) ? 75 : 25;
      fifo_cycle($urandom_range(0, 99) < p_push, rand_word(), $urandom_range(0, 99) >= p_push,
                 $urandom_range(0, 99) < p_push, rand_word(), $urandom_range(0, 99) >= p_push,
                 "rand_fifo");
    end
    while (rx_q.size() > 0 || tx_q.size() > 0) fifo_cycle(0, '0, 1, 0, '0, 1, "drain");

    // RX simultaneous push/pop at count 4, then pop-on-empty with push
    for (int i = 0; i < 4; i++) fifo_cycle(0, '0, 0, 1, word_t'(100 + i), 0, "rx_fill4");
    fifo_cycle(0, '0, 0, 1, word_t'(200), 1, "rx_push_pop");
    for (int i = 0; i < 4; i++) fifo_cycle(0, '0, 0, 0, '0, 1, "rx_pop4");
    check("rx_empty_after4", word_t'(fifo_read_wait), word_t'(1));
    fifo_cycle(0, '0, 0, 1, word_t'(300), 1, "rx_pop_empty_push");
    fifo_cycle(0, '0, 0, 0, '0, 1, "rx_pop_single");

    // Command execute: start at N+1, completion at N+5, done at N+6
    seq_cycle(1, 0, 0, 0, '0, "cmd_new");
    rd_reg(13, "status_cmd_busy");
    repeat (3) seq_cycle(0, 0, 0, 0, '0, "cmd_wait");
    seq_cycle(0, 0, 1, 0, word_t'(16'h1234), "cmd_complete");
    rd_reg(14, "resp_1234");
    check("resp_const", ref_resp, word_t'(16'h1234));

    // Data execute with completion in the start cycle; wrong-kind completion
    seq_cycle(0, 1, 0, 0, '0, "data_new");
    seq_cycle(0, 0, 0, 1, '0, "data_complete_in_start");
    seq_cycle(0, 1, 0, 0, '0, "data_new2");
    seq_cycle(0, 0, 1, 0, rand_word(), "data_wrong_kind");
    rd_reg(13, "status_data_busy");
    seq_cycle(0, 0, 0, 1, '0, "data_complete2");
    seq_cycle(0, 0, 0, 1, '0, "complete_in_idle");

    // Overrun: data pulse while command busy, then clear
    seq_cycle(1, 0, 0, 0, '0, "ovr_cmd");
    seq_cycle(0, 1, 0, 0, '0, "ovr_data_while_busy");
    rd_reg(13, "status_overrun_set");
    seq_cycle(0, 0, 1, 0, rand_word(), "ovr_cmd_done");
    wr_reg(13, word_t'(7'h40));
    rd_reg(13, "status_overrun_clear");
    seq_cycle(1, 1, 0, 0, '0, "both_pulses");
    rd_reg(13, "status_both");
    seq_cycle(0, 0, 1, 0, rand_word(), "both_done");
    wr_reg(13, word_t'(7'h40));

    // Random sequencer traffic
    repeat (60) begin
      seq_cycle($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, rand_word(), "rand_seq");
      if ($urandom_range(0, 3) == 0) rd_reg(5'($urandom_range(13, 14)), "rand_seq_rd");
    end

    // Reset during DATA_BUSY with 3 TX entries
    while (ref_cmd_busy || ref_data_busy) seq_cycle(0, 0, 1, 1, rand_word(), "settle");
    for (int i = 0; i < 3; i++) fifo_cycle(1, rand_word(), 0, 0, '0, 0, "pre_reset_tx");
    seq_cycle(0, 1, 0, 0, '0, "pre_reset_data");
    do_reset();
    check("reset_tx_empty", word_t'(tx_empty_o), word_t'(1));
    rd_reg(13, "status_after_reset");
    rd_reg(0, "reg0_after_reset");
    seq_cycle(0, 0, 0, 1, '0, "no_done_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
